// File: rtl/bank_cmd_scheduler_if.sv
// bank_cmd_scheduler_if: request handshake and command bus between a requester, the scheduler and command_sender
// master: drives req_valid_in/req_write_in/req_addr_in/req_data_in, observes ready and command fields
// slave : the scheduler side, the mirror image of master
interface bank_cmd_scheduler_if #(
  parameter int BANK_GROUPS = 4,
  parameter int BANKS_PER_GROUP = 2,
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int PADDR_BITS = 64
);
  localparam int BG_W = $clog2(BANK_GROUPS);
  localparam int BA_W = $clog2(BANKS_PER_GROUP);
  logic req_valid_in;
  logic req_ready_out;
  logic req_write_in;
  logic [PADDR_BITS-1:0] req_addr_in;
  logic [7:0][63:0] req_data_in;
  logic valid_out;
  logic [2:0] cmd_out;
  logic [BG_W-1:0] bank_group_out;
  logic [BA_W-1:0] bank_out;
  logic [ROW_BITS-1:0] row_out;
  logic [COL_BITS-1:0] col_out;
  logic [7:0][63:0] val_out;
  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_data_in,
    input req_ready_out, valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out, val_out
  );
  modport slave (
    input req_valid_in, req_write_in, req_addr_in, req_data_in,
    output req_ready_out, valid_out, cmd_out, bank_group_out, bank_out, row_out, col_out, val_out
  );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler: in-order open-page DRAM command scheduler feeding command_sender
// clk_in/rst_in: clock and synchronous active-high reset
// bus (slave): req_valid_in/req_ready_out handshake with req_write_in, req_addr_in, req_data_in;
//              valid_out strobe with cmd_out, bank_group_out, bank_out, row_out, col_out, val_out
module bank_cmd_scheduler #(
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY = 5,
  parameter int BURST_GAP = 8,
  parameter int BANK_GROUPS = 4,
  parameter int BANKS_PER_GROUP = 2,
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 4,
  parameter int PADDR_BITS = 64
) (
  input logic clk_in,
  input logic rst_in,
  bank_cmd_scheduler_if.slave bus
);
  localparam int BG_W = $clog2(BANK_GROUPS);
  localparam int BA_W = $clog2(BANKS_PER_GROUP);
  localparam int IW = BG_W + BA_W;
  localparam int NB = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int USED = COL_BITS + IW + ROW_BITS;
  localparam int MAX_AP = ACTIVATION_LATENCY > PRECHARGE_LATENCY ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int MAX_LAT = MAX_AP > BURST_GAP ? MAX_AP : BURST_GAP;
  localparam int CW = $clog2(MAX_LAT);
  localparam logic [2:0] CMD_RD = 3'd0;
  localparam logic [2:0] CMD_WR = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_PRE = 3'd3;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_PRE, ACT, WAIT_ACT, ACCESS, WAIT_BURST} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic write_q;
  logic [NB-1:0] bank_open;
  logic [NB-1:0][ROW_BITS-1:0] bank_row;
  logic [COL_BITS-1:0] a_col;
  logic [BA_W-1:0] a_ba;
  logic [BG_W-1:0] a_bg;
  logic [ROW_BITS-1:0] a_row;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] idx;
  logic unused_addr;
  assign a_col = bus.req_addr_in[COL_BITS-1:0];
  assign a_ba = bus.req_addr_in[COL_BITS +: BA_W];
  assign a_bg = bus.req_addr_in[COL_BITS+BA_W +: BG_W];
  assign a_row = bus.req_addr_in[COL_BITS+IW +: ROW_BITS];
  assign a_idx = {a_bg, a_ba};
  assign idx = {bus.bank_group_out, bus.bank_out};
  assign unused_addr = ^bus.req_addr_in[PADDR_BITS-1:USED];
  assign bus.req_ready_out = state == IDLE;
  // WAIT_* states are entered one cycle after the command, so the counter is
  // loaded with latency-2 and the exit happens on the cycle it reads zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      write_q <= 1'b0;
      bank_open <= '0;
      bus.valid_out <= 1'b0;
      bus.cmd_out <= '0;
      bus.bank_group_out <= '0;
      bus.bank_out <= '0;
      bus.row_out <= '0;
      bus.col_out <= '0;
      bus.val_out <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid_in) begin
          bus.col_out <= a_col;
          bus.bank_out <= a_ba;
          bus.bank_group_out <= a_bg;
          bus.row_out <= a_row;
          bus.val_out <= bus.req_data_in;
          write_q <= bus.req_write_in;
          bus.valid_out <= 1'b1;
          if (!bank_open[a_idx]) begin
            state <= ACT;
            bus.cmd_out <= CMD_ACT;
          end else if (bank_row[a_idx] == a_row) begin
            state <= ACCESS;
            bus.cmd_out <= bus.req_write_in ? CMD_WR : CMD_RD;
          end else begin
            state <= PRE;
            bus.cmd_out <= CMD_PRE;
          end
        end
        PRE: begin
          bank_open[idx] <= 1'b0;
          cnt <= CW'(PRECHARGE_LATENCY - 2);
          state <= WAIT_PRE;
        end
        WAIT_PRE: if (cnt == '0) begin
          state <= ACT;
          bus.valid_out <= 1'b1;
          bus.cmd_out <= CMD_ACT;
        end else cnt <= cnt - 1'b1;
        ACT: begin
          bank_open[idx] <= 1'b1;
          bank_row[idx] <= bus.row_out;
          cnt <= CW'(ACTIVATION_LATENCY - 2);
          state <= WAIT_ACT;
        end
        WAIT_ACT: if (cnt == '0) begin
          state <= ACCESS;
          bus.valid_out <= 1'b1;
          bus.cmd_out <= write_q ? CMD_WR : CMD_RD;
        end else cnt <= cnt - 1'b1;
        ACCESS: begin
          cnt <= CW'(BURST_GAP - 2);
          state <= WAIT_BURST;
        end
        WAIT_BURST: if (cnt == '0) state <= IDLE;
        else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
